// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage: owns the program counter and the IF/ID pipeline
// register. The PC drives instruction memory combinationally, and the returned
// word is captured into IF/ID on the next rising edge. Redirects, stalls and
// flushes from the rest of the pipeline decide whether the PC advances, holds
// or jumps, and whether IF/ID captures, holds or takes a bubble.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   - a redirect to a target that is not word aligned raises
//               fetch_exc. The PC then freezes and bubbles are issued until a
//               later redirect to an aligned target arrives.
//   undefined - redirect targets are forced to word alignment and fetch_exc
//               is always 0.
//
// Ports
//   clk              clock; all state changes on its rising edge
//   rst              asynchronous active-high reset
//   instr_addr       byte address to instruction memory (current PC)
//   instr_data       instruction word returned by memory for instr_addr
//   stall            hold the PC and IF/ID
//   flush            squash IF/ID into a bubble
//   redirect_valid   taken branch/jump; load redirect_target
//   redirect_target  next PC on redirect
//   if_id_valid      IF/ID holds a real instruction
//   if_id_pc         PC of the registered instruction
//   if_id_pc_plus4   if_id_pc + 4 (wraps modulo 2^32)
//   if_id_instr      registered instruction word
//   fetch_count      number of valid instructions captured into IF/ID
//   fetch_exc        misaligned-redirect exception pending
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic [31:0] fetch_count,
    output logic        fetch_exc
);

    logic [31:0] pc_q, pc_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        fetch_exc_q, fetch_exc_d;

    logic [31:0] pc_plus4;
    logic        redirect_misaligned;
    logic [31:0] redirect_pc;
    logic        bubble;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_misaligned = (redirect_target[1:0] != 2'b00);
    assign redirect_pc         = redirect_target;
`else
    assign redirect_misaligned = 1'b0;
    // Low bits are dropped so a stray target still lands on a word boundary.
    assign redirect_pc         = redirect_target & 32'hFFFF_FFFC;
`endif

    // A pending exception keeps issuing bubbles even over a stall so that
    // nothing downstream executes past the faulting redirect.
    assign bubble = redirect_valid | flush | fetch_exc_q;

    always_comb begin
        pc_d             = pc_q;
        fetch_exc_d      = fetch_exc_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_instr_d    = if_id_instr_q;
        fetch_count_d    = fetch_count_q;

        if (redirect_valid) begin
            if (redirect_misaligned) begin
                fetch_exc_d = 1'b1;
            end else begin
                fetch_exc_d = 1'b0;
                pc_d        = redirect_pc;
            end
        end else if (!stall && !fetch_exc_q) begin
            pc_d = pc_plus4;
        end

        if (bubble) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (!stall) begin
            if_id_valid_d    = 1'b1;
            if_id_pc_d       = pc_q;
            if_id_pc_plus4_d = pc_plus4;
            if_id_instr_d    = instr_data;
            fetch_count_d    = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            fetch_exc_q      <= 1'b0;
            if_id_valid_q    <= 1'b0;
            if_id_pc_q       <= 32'h0000_0000;
            if_id_pc_plus4_q <= 32'h0000_0000;
            if_id_instr_q    <= NOP_INSTR;
            fetch_count_q    <= 32'h0000_0000;
        end else begin
            pc_q             <= pc_d;
            fetch_exc_q      <= fetch_exc_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_instr_q    <= if_id_instr_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign instr_addr     = pc_q;
    assign if_id_valid    = if_id_valid_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_instr    = if_id_instr_q;
    assign fetch_count    = fetch_count_q;
    assign fetch_exc      = fetch_exc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Bench for fetch_stage. Instruction memory word at byte address A is A/4.
// A transaction-level reference model tracks the architectural PC and the
// IF/ID contents. Directed scenarios are followed by randomized traffic, and
// every edge is checked against the model.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic [31:0] fetch_count;
    logic        fetch_exc;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;
    logic        m_exc;

    always #5 clk = ~clk;

    assign instr_data = instr_addr >> 2;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_addr      (instr_addr),
        .instr_data      (instr_data),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_instr     (if_id_instr),
        .fetch_count     (fetch_count),
        .fetch_exc       (fetch_exc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_valid = 1'b0;
        m_ipc   = 32'h0;
        m_ipc4  = 32'h0;
        m_instr = NOP_INSTR;
        m_cnt   = 32'h0;
        m_exc   = 1'b0;
    endtask

    // One pipeline edge, described as what the stage is supposed to do with the
    // instruction currently at the PC, then where the PC goes next.
    task automatic model_step();
        bit kill;
        bit misaligned;
        kill = redirect_valid || flush || m_exc;
        if (kill) begin
            m_valid = 1'b0;
            m_instr = NOP_INSTR;
        end else if (!stall) begin
            m_valid = 1'b1;
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_instr = m_pc / 4;
            m_cnt   = m_cnt + 32'd1;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned = (redirect_target % 4) != 0;
`else
        misaligned = 1'b0;
`endif
        if (redirect_valid) begin
            if (misaligned) begin
                m_exc = 1'b1;
            end else begin
                m_exc = 1'b0;
                m_pc  = redirect_target - (redirect_target % 4);
            end
        end else if (!stall && !m_exc) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},       instr_addr,            m_pc);
        chk({tag, ".valid"},    {31'b0, if_id_valid},  {31'b0, m_valid});
        chk({tag, ".ifid_pc"},  if_id_pc,              m_ipc);
        chk({tag, ".ifid_pc4"}, if_id_pc_plus4,        m_ipc4);
        chk({tag, ".instr"},    if_id_instr,           m_instr);
        chk({tag, ".count"},    fetch_count,           m_cnt);
        chk({tag, ".exc"},      {31'b0, fetch_exc},    {31'b0, m_exc});
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic s, input logic f, input logic rv, input logic [31:0] rt);
        stall           = s;
        flush           = f;
        redirect_valid  = rv;
        redirect_target = rt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();

        // sequential fetch from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick("seq");
            chk("seq.pc_const",    if_id_pc,    32'(4 * i));
            chk("seq.instr_const", if_id_instr, 32'(i));
        end
        chk("seq.count_const", fetch_count, 32'd4);

        // stall for 3 cycles at pc 8
        do_reset();
        tick("pre_stall");
        tick("pre_stall");
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            chk("stall.pc_const",    instr_addr, 32'd8);
            chk("stall.ifid_const",  if_id_pc,   32'd4);
            chk("stall.count_const", fetch_count, 32'd2);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick("stall_rel");
        chk("stall_rel.ifid_const", if_id_pc, 32'd8);

        // redirect overriding stall at pc 12
        drive(1'b1, 1'b0, 1'b1, 32'h40);
        tick("redir_stall");
        chk("redir_stall.pc_const",    instr_addr,  32'h40);
        chk("redir_stall.valid_const", {31'b0, if_id_valid}, 32'd0);
        chk("redir_stall.nop_const",   if_id_instr, 32'h13);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick("redir_after");
        chk("redir_after.ifid_const", if_id_pc, 32'h40);

        // flush with and without stall
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick("flush");
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick("flush_stall");
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick("flush_done");

        // PC wrap at the top of the address space
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick("wrap_redir");
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick("wrap");
        chk("wrap.pc4_const", if_id_pc_plus4, 32'h0);
        chk("wrap.pc_const",  instr_addr,     32'h0);

        // misaligned redirect
        drive(1'b0, 1'b0, 1'b1, 32'h42);
        tick("mis");
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis.exc_const", {31'b0, fetch_exc}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick("mis_hold");
            chk("mis_hold.valid_const", {31'b0, if_id_valid}, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b1, 32'h80);
        tick("mis_clear");
        chk("mis_clear.exc_const", {31'b0, fetch_exc}, 32'd0);
        chk("mis_clear.pc_const",  instr_addr,         32'h80);
`else
        chk("mis.pc_const",  instr_addr,         32'h40);
        chk("mis.exc_const", {31'b0, fetch_exc}, 32'd0);
`endif
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick("mis_after");

        // asynchronous reset during a stall at pc 0x20
        drive(1'b0, 1'b0, 1'b1, 32'h20);
        tick("ar_redir");
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick("ar_stall");
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_rst.pc_const", instr_addr, RESET_PC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick("ar_first");
        chk("ar_first.ifid_const", if_id_pc, 32'h0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] tgt;
            case ($urandom_range(0, 3))
                0: tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1: tgt = 32'($urandom_range(0, 255));
                default: tgt = $urandom;
            endcase
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 9) == 0, tgt);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
